// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller: widths, FSM encoding and
// the address-alignment helper.
package mem_stage_ctrl_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int REG_W           = 5;

    // Memory-access sequencer: IDLE accepts bundles, ACCESS waits for the ack.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Only whole-word accesses are supported; any low address bit set is an error.
    function automatic logic word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register. A load cycle captures a full bundle and marks it
// valid; any other cycle inserts a bubble while the payload fields hold.
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iLoad,
    input  logic             iRegWrite,
    input  logic [REG_W-1:0] iRegDest,
    input  logic [XLEN-1:0]  iWBData,
    input  logic [XLEN-1:0]  iIR,
    input  logic [XLEN-1:0]  iPC,
    output logic             oValid,
    output logic             oRegWrite,
    output logic [REG_W-1:0] oRegDest,
    output logic [XLEN-1:0]  oWBData,
    output logic [XLEN-1:0]  oIR,
    output logic [XLEN-1:0]  oPC
);

    logic             valid_q;
    logic             reg_write_q;
    logic [REG_W-1:0] reg_dest_q;
    logic [XLEN-1:0]  wb_data_q;
    logic [XLEN-1:0]  ir_q;
    logic [XLEN-1:0]  pc_q;

    // Bundle capture on load, bubble otherwise; a bubble never writes the register file.
    // NOTE: state is updated with <= so every flop samples the pre-edge values,
    // regardless of the order the statements appear in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            reg_dest_q  <= '0;
            wb_data_q   <= '0;
            ir_q        <= '0;
            pc_q        <= '0;
        end else begin
            valid_q     <= iLoad;
            reg_write_q <= iLoad & iRegWrite;
            if (iLoad) begin
                reg_dest_q <= iRegDest;
                wb_data_q  <= iWBData;
                ir_q       <= iIR;
                pc_q       <= iPC;
            end
        end
    end

    assign oValid    = valid_q;
    assign oRegWrite = reg_write_q;
    assign oRegDest  = reg_dest_q;
    assign oWBData   = wb_data_q;
    assign oIR       = ir_q;
    assign oPC       = pc_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: accepts the EX/MEM bundle, runs the data-memory
// req/ack access with a timeout, resolves branch/jump redirect and feeds the
// MEM/WB register. Stalls the front of the pipe while an access is pending.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iValid,
    input  logic [XLEN-1:0]  iIR,
    input  logic [XLEN-1:0]  iPC,
    input  logic [XLEN-1:0]  iResult,
    input  logic [XLEN-1:0]  iWriteData,
    input  logic [XLEN-1:0]  iBranch,
    input  logic [XLEN-1:0]  iJump,
    input  logic             iZero,
    input  logic             iBranchs,
    input  logic             iJumps,
    input  logic             iRegWrite,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic             iMemToReg,
    input  logic [REG_W-1:0] iRegDest,
    output logic             oStall,
    output logic             oRedirect,
    output logic [XLEN-1:0]  oTarget,
    output logic             oMemReq,
    output logic             oMemWe,
    output logic [XLEN-1:0]  oMemAddr,
    output logic [XLEN-1:0]  oMemWData,
    input  logic             iMemAck,
    input  logic [XLEN-1:0]  iMemRData,
    output logic             oMemErr,
    output logic             oValid,
    output logic             oRegWrite,
    output logic [REG_W-1:0] oRegDest,
    output logic [XLEN-1:0]  oWBData,
    output logic [XLEN-1:0]  oIR,
    output logic [XLEN-1:0]  oPC
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Fields of the accepted bundle needed once the access completes.
    typedef struct packed {
        logic [XLEN-1:0]  ir;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] reg_dest;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
    } held_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             err_q, err_d;
    held_t            held_q, held_d;

    logic             accept;
    logic             mem_op;
    logic             start_access;
    logic             wb_load;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_reg_dest;
    logic [XLEN-1:0]  wb_data;
    logic [XLEN-1:0]  wb_ir;
    logic [XLEN-1:0]  wb_pc;

    // Reset gates acceptance so every output reads zero while reset is held.
    assign accept       = iValid & (state_q == ST_IDLE) & ~reset;
    assign mem_op       = iMemRead | iMemWrite;
    assign start_access = accept & mem_op & word_aligned(iResult[1:0]);

    assign oStall    = start_access | (state_q == ST_ACCESS);
    assign oRedirect = accept & (iJumps | (iBranchs & iZero));
    assign oTarget   = oRedirect ? (iJumps ? iJump : iBranch) : '0;

    // Next-state, request fields and MEM/WB load selection.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        held_d       = held_q;
        err_d        = 1'b0;
        wb_load      = 1'b0;
        wb_reg_write = 1'b0;
        wb_reg_dest  = iRegDest;
        wb_data      = iResult;
        wb_ir        = iIR;
        wb_pc        = iPC;

        case (state_q)
            ST_IDLE: begin
                if (start_access) begin
                    state_d           = ST_ACCESS;
                    cnt_d             = '0;
                    req_d             = 1'b1;
                    we_d              = iMemWrite;
                    addr_d            = iResult;
                    wdata_d           = iWriteData;
                    held_d.ir         = iIR;
                    held_d.pc         = iPC;
                    held_d.reg_dest   = iRegDest;
                    held_d.reg_write  = iRegWrite;
                    held_d.mem_to_reg = iMemToReg;
                    held_d.mem_write  = iMemWrite;
                end else if (accept) begin
                    // Plain ALU result, or a misaligned access reported as an error.
                    wb_load      = 1'b1;
                    wb_reg_write = iRegWrite & ~mem_op;
                    err_d        = mem_op;
                end
            end
            ST_ACCESS: begin
                wb_reg_dest = held_q.reg_dest;
                wb_data     = addr_q;
                wb_ir       = held_q.ir;
                wb_pc       = held_q.pc;
                if (iMemAck || cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wb_load = 1'b1;
                    if (iMemAck) begin
                        wb_reg_write = held_q.reg_write & ~held_q.mem_write;
                        if (held_q.mem_to_reg) begin
                            wb_data = iMemRData;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, timeout counter, request outputs and captured bundle fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            held_q  <= held_d;
        end
    end

    assign oMemReq   = req_q;
    assign oMemWe    = we_q;
    assign oMemAddr  = addr_q;
    assign oMemWData = wdata_q;
    assign oMemErr   = err_q;

    mem_wb_reg #(
        .XLEN (XLEN)
    ) u_mem_wb_reg (
        .clock     (clock),
        .reset     (reset),
        .iLoad     (wb_load),
        .iRegWrite (wb_reg_write),
        .iRegDest  (wb_reg_dest),
        .iWBData   (wb_data),
        .iIR       (wb_ir),
        .iPC       (wb_pc),
        .oValid    (oValid),
        .oRegWrite (oRegWrite),
        .oRegDest  (oRegDest),
        .oWBData   (oWBData),
        .oIR       (oIR),
        .oPC       (oPC)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Transaction-level bench for mem_stage_ctrl: each instruction is applied as a
// whole, and the expected stall length, request fields, redirect and MEM/WB
// bundle are derived from the instruction kind and the chosen ack delay.
module tb_mem_stage_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            iValid;
    logic [XLEN-1:0] iIR, iPC, iResult, iWriteData, iBranch, iJump;
    logic            iZero, iBranchs, iJumps, iRegWrite, iMemRead, iMemWrite, iMemToReg;
    logic [4:0]      iRegDest;
    logic            oStall, oRedirect, oMemReq, oMemWe, oMemErr;
    logic [XLEN-1:0] oTarget, oMemAddr, oMemWData;
    logic            iMemAck;
    logic [XLEN-1:0] iMemRData;
    logic            oValid, oRegWrite;
    logic [4:0]      oRegDest;
    logic [XLEN-1:0] oWBData, oIR, oPC;

    int n_vec  = 0;
    int n_miss = 0;

    // One instruction as it sits in EX/MEM.
    typedef struct packed {
        logic [31:0] ir, pc, res, wdata, br, jp;
        logic [4:0]  rd;
        logic        zero, bs, js, rw, mr, mw, m2r;
    } op_t;

    // Last bundle delivered to MEM/WB: these fields must hold across bubbles.
    logic [31:0] last_ir, last_pc;
    logic [4:0]  last_rd;

    mem_stage_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .iValid(iValid), .iIR(iIR), .iPC(iPC),
        .iResult(iResult), .iWriteData(iWriteData), .iBranch(iBranch), .iJump(iJump),
        .iZero(iZero), .iBranchs(iBranchs), .iJumps(iJumps), .iRegWrite(iRegWrite),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iRegDest(iRegDest), .oStall(oStall), .oRedirect(oRedirect), .oTarget(oTarget),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .iMemAck(iMemAck), .iMemRData(iMemRData), .oMemErr(oMemErr), .oValid(oValid),
        .oRegWrite(oRegWrite), .oRegDest(oRegDest), .oWBData(oWBData), .oIR(oIR), .oPC(oPC)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        iValid = 1'b0; iIR = '0; iPC = '0; iResult = '0; iWriteData = '0;
        iBranch = '0; iJump = '0; iZero = 1'b0; iBranchs = 1'b0; iJumps = 1'b0;
        iRegWrite = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0; iMemToReg = 1'b0;
        iRegDest = '0; iMemAck = 1'b0; iMemRData = '0;
    endtask

    task automatic drive_op(input op_t o);
        iValid = 1'b1; iIR = o.ir; iPC = o.pc; iResult = o.res; iWriteData = o.wdata;
        iBranch = o.br; iJump = o.jp; iZero = o.zero; iBranchs = o.bs; iJumps = o.js;
        iRegWrite = o.rw; iMemRead = o.mr; iMemWrite = o.mw; iMemToReg = o.m2r;
        iRegDest = o.rd;
    endtask

    // Garbage on the EX/MEM inputs while an access is pending: nothing may change.
    task automatic drive_junk();
        iValid = 1'($urandom); iIR = $urandom; iPC = $urandom; iResult = $urandom;
        iWriteData = $urandom; iBranch = $urandom; iJump = $urandom;
        iZero = 1'($urandom); iBranchs = 1'($urandom); iJumps = 1'($urandom);
        iRegWrite = 1'($urandom); iMemRead = 1'($urandom); iMemWrite = 1'($urandom);
        iMemToReg = 1'($urandom); iRegDest = 5'($urandom);
    endtask

    // Apply one instruction. ack_delay = ACCESS cycle in which ack is high (0 = never).
    task automatic run_op(input op_t o, input int ack_delay, input logic [31:0] rdata);
        logic is_mem, misal, redir, timed_out;
        is_mem    = o.mr | o.mw;
        misal     = (o.res[1:0] != 2'b00);
        redir     = o.js | (o.bs & o.zero);
        timed_out = (ack_delay == 0);

        drive_op(o);
        iMemAck = 1'($urandom);   // ack while idle must be ignored
        #1;
        check("redirect", oRedirect, redir);
        if (redir) check("target", oTarget, o.js ? o.jp : o.br);
        check("stall_accept", oStall, is_mem & ~misal);

        if (!is_mem || misal) begin
            step();
            drive_idle();
            #1;
            check("valid", oValid, 1);
            check("regwrite", oRegWrite, is_mem ? 1'b0 : o.rw);
            check("memerr", oMemErr, is_mem);
            check("memreq_none", oMemReq, 0);
            check("stall_after", oStall, 0);
            if (!is_mem) check("wbdata_alu", oWBData, o.res);
        end else begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                step();
                drive_junk();
                iMemAck   = (k == ack_delay);
                iMemRData = (k == ack_delay) ? rdata : $urandom;
                #1;
                check("memreq", oMemReq, 1);
                check("memaddr", oMemAddr, o.res);
                check("memwe", oMemWe, o.mw);
                check("memwdata", oMemWData, o.wdata);
                check("stall_access", oStall, 1);
                check("redirect_access", oRedirect, 0);
                check("valid_access", oValid, 0);
                check("memerr_access", oMemErr, 0);
                if (k == ack_delay) break;
            end
            step();
            drive_idle();
            #1;
            check("valid_done", oValid, 1);
            check("memerr_done", oMemErr, timed_out);
            check("memreq_done", oMemReq, 0);
            check("memwe_done", oMemWe, 0);
            check("stall_done", oStall, 0);
            check("regwrite_done", oRegWrite, timed_out ? 1'b0 : (o.rw & ~o.mw));
            if (!timed_out) check("wbdata_mem", oWBData, o.m2r ? rdata : o.res);
        end
        check("regdest", oRegDest, o.rd);
        check("ir", oIR, o.ir);
        check("pc", oPC, o.pc);
        last_ir = o.ir;
        last_pc = o.pc;
        last_rd = o.rd;
    endtask

    task automatic bubbles(input int n);
        repeat (n) begin
            step();
            #1;
            check("bubble_valid", oValid, 0);
            check("bubble_memerr", oMemErr, 0);
            check("bubble_ir_hold", oIR, last_ir);
            check("bubble_pc_hold", oPC, last_pc);
            check("bubble_rd_hold", oRegDest, last_rd);
        end
    endtask

    task automatic gen_op(output op_t o);
        logic [31:0] addr;
        int kind;
        o = '0;
        o.ir = $urandom; o.pc = $urandom; o.wdata = $urandom;
        o.br = $urandom; o.jp = $urandom; o.rd = 5'($urandom);
        o.zero = 1'($urandom); o.bs = 1'($urandom); o.js = 1'($urandom);
        o.rw = 1'($urandom);
        kind = $urandom_range(0, 2);
        addr = $urandom;
        if (kind != 0) begin
            if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            else addr[1:0] = 2'b00;
            o.mr  = (kind == 1);
            o.mw  = (kind == 2);
            o.m2r = (kind == 1);
        end
        o.res = addr;
    endtask

    initial begin
        op_t o;
        int  dly;
        last_ir = '0; last_pc = '0; last_rd = '0;
        reset = 1'b1;
        drive_idle();
        #1;
        check("rst_valid", oValid, 0);
        check("rst_memreq", oMemReq, 0);
        check("rst_stall", oStall, 0);
        check("rst_memerr", oMemErr, 0);
        check("rst_wbdata", oWBData, 0);
        check("rst_pc", oPC, 0);
        step();
        step();
        reset = 1'b0;
        bubbles(1);

        // ALU op
        o = '0; o.res = 32'h0000_00F0; o.rd = 5'd7; o.rw = 1'b1; o.ir = 32'h1111; o.pc = 32'h20;
        run_op(o, 1, '0);
        // Load, ack in the third ACCESS cycle: stall is high 4 cycles in total
        o = '0; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.res = 32'h100; o.rd = 5'd3; o.pc = 32'h24;
        run_op(o, 3, 32'hDEAD_BEEF);
        // Store, immediate ack
        o = '0; o.mw = 1'b1; o.res = 32'h104; o.wdata = 32'h5A5A_5A5A; o.rw = 1'b1; o.pc = 32'h28;
        run_op(o, 1, 32'h1234_5678);
        // Taken branch, then branch with jump priority
        o = '0; o.bs = 1'b1; o.zero = 1'b1; o.br = 32'h40; o.jp = 32'h80; o.pc = 32'h2C;
        run_op(o, 1, '0);
        o.js = 1'b1;
        run_op(o, 1, '0);
        bubbles(1);
        // Misaligned load
        o = '0; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.res = 32'h102; o.rd = 5'd9;
        run_op(o, 1, '0);
        // Aligned load that never gets an ack
        o = '0; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.res = 32'h200; o.rd = 5'd4;
        run_op(o, 0, '0);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            gen_op(o);
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            run_op(o, dly, $urandom);
            bubbles($urandom_range(0, 2));
        end

        // Reset two cycles into an access
        o = '0; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.res = 32'h300; o.rd = 5'd5;
        drive_op(o);
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst_memreq", oMemReq, 0);
        check("midrst_stall", oStall, 0);
        check("midrst_valid", oValid, 0);
        check("midrst_redirect", oRedirect, 0);
        step();
        reset = 1'b0;
        drive_idle();
        #1;
        check("postrst_valid", oValid, 0);
        check("postrst_memreq", oMemReq, 0);
        check("postrst_stall", oStall, 0);
        o = '0; o.res = 32'hCAFE_0000; o.rd = 5'd12; o.rw = 1'b1; o.pc = 32'h400;
        run_op(o, 1, '0);
        bubbles(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
